// File: rtl/iq_fifo_reader.sv
// Read side of the IQ sample FIFO: prefetches one I/Q byte pair into a holding
// buffer and hands it out on each sample request, substituting zeros on underrun.
module iq_fifo_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  fifo_data_out,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic        sample_stb,
    output logic [7:0]  iq_i,
    output logic [7:0]  iq_q,
    output logic        iq_stb,
    output logic        underrun,
    output logic [15:0] underrun_count,
    input  logic        count_clr
);

    typedef enum logic [2:0] {
        S_FETCH_I = 3'd0,
        S_CAP_I   = 3'd1,
        S_FETCH_Q = 3'd2,
        S_CAP_Q   = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  buf_i_q, buf_i_d;
    logic [7:0]  buf_q_q, buf_q_d;
    logic        buf_valid_q, buf_valid_d;
    logic [7:0]  iq_i_q, iq_i_d;
    logic [7:0]  iq_q_q, iq_q_d;
    logic        iq_stb_q, iq_stb_d;
    logic        underrun_q, underrun_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fetch_ok;

    // Gated by rst as well so nothing is pulled from the FIFO while held in reset.
    assign fetch_ok = enable & ~fifo_empty & ~rst;
    assign fifo_rd  = fetch_ok & ((state_q == S_FETCH_I) | (state_q == S_FETCH_Q));

    always_comb begin
        state_d     = state_q;
        buf_i_d     = buf_i_q;
        buf_q_d     = buf_q_q;
        buf_valid_d = buf_valid_q;
        iq_i_d      = iq_i_q;
        iq_q_d      = iq_q_q;
        iq_stb_d    = 1'b0;
        underrun_d  = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            S_FETCH_I: if (fetch_ok) state_d = S_CAP_I;
            S_CAP_I: begin
                buf_i_d = fifo_data_out;
                state_d = S_FETCH_Q;
            end
            S_FETCH_Q: if (fetch_ok) state_d = S_CAP_Q;
            S_CAP_Q: begin
                buf_q_d     = fifo_data_out;
                buf_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD:    state_d = S_HOLD;
            default:   state_d = S_FETCH_I;
        endcase

        // A request during S_CAP_Q sees buf_valid_q low and underruns; the pair is kept.
        if (sample_stb) begin
            iq_stb_d = 1'b1;
            if (enable && buf_valid_q) begin
                iq_i_d      = buf_i_q;
                iq_q_d      = buf_q_q;
                buf_valid_d = 1'b0;
                state_d     = S_FETCH_I;
            end else begin
                iq_i_d = 8'h00;
                iq_q_d = 8'h00;
                if (enable) begin
                    underrun_d = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end
        end

        if (count_clr) cnt_d = 16'h0000;

        if (!enable) begin
            state_d     = S_FETCH_I;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH_I;
            buf_i_q     <= 8'h00;
            buf_q_q     <= 8'h00;
            buf_valid_q <= 1'b0;
            iq_i_q      <= 8'h00;
            iq_q_q      <= 8'h00;
            iq_stb_q    <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            buf_i_q     <= buf_i_d;
            buf_q_q     <= buf_q_d;
            buf_valid_q <= buf_valid_d;
            iq_i_q      <= iq_i_d;
            iq_q_q      <= iq_q_d;
            iq_stb_q    <= iq_stb_d;
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign iq_i           = iq_i_q;
    assign iq_q           = iq_q_q;
    assign iq_stb         = iq_stb_q;
    assign underrun       = underrun_q;
    assign underrun_count = cnt_q;

endmodule

// File: doc/iq_fifo_reader.md
# iq_fifo_reader

Read side of the IQ sample FIFO. The SPI packet controller fills the FIFO with byte-interleaved I/Q samples. This block drains the FIFO one I/Q pair at a time and prefetches the next pair into a holding buffer. On each sample request from the modulator/DAC path it presents the buffered pair. When the buffer is not ready it emits a zero sample and counts an underrun.

## Interface
- No parameters.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  run control; low stops reads and flushes the buffer.
- fifo_data_out  input  8  FIFO read data; valid the cycle after fifo_rd.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO read pulse, one cycle per byte.
- sample_stb  input  1  one-cycle request for the next sample, from the modulator.
- iq_i  output  8  current I sample, signed two's complement, registered.
- iq_q  output  8  current Q sample, signed two's complement, registered.
- iq_stb  output  1  pulses one cycle when iq_i/iq_q update.
- underrun  output  1  pulses with iq_stb when a zero sample was substituted.
- underrun_count  output  16  saturating count of underruns.
- count_clr  input  1  synchronous clear of underrun_count.

## Operation
- Byte order in the FIFO: I first, then Q. Each pair is one sample.
- Internal holding buffer: buf_i, buf_q, buf_valid.
- State machine states:
  - S_FETCH_I: if enable and !fifo_empty, assert fifo_rd and go to S_CAP_I; otherwise stay.
  - S_CAP_I: buf_i <= fifo_data_out; go to S_FETCH_Q.
  - S_FETCH_Q: if enable and !fifo_empty, assert fifo_rd and go to S_CAP_Q; otherwise stay.
  - S_CAP_Q: buf_q <= fifo_data_out; buf_valid <= 1; go to S_HOLD.
  - S_HOLD: wait for the buffer to be consumed.
  - Any undefined encoding goes to S_FETCH_I.
- fifo_rd is combinationally gated by !fifo_empty, so the block never reads an empty FIFO.
- sample_stb with buf_valid=1 and enable=1:
  - iq_i <= buf_i, iq_q <= buf_q, iq_stb <= 1.
  - buf_valid <= 0; state S_HOLD -> S_FETCH_I.
- sample_stb with buf_valid=0 and enable=1:
  - iq_i <= 0, iq_q <= 0, iq_stb <= 1, underrun <= 1.
  - underrun_count increments, saturating at 16'hFFFF.
  - The fetch in progress continues undisturbed.
- sample_stb in the same cycle as S_CAP_Q: the buffer is not yet valid, so this is an underrun. The pair becomes valid next cycle and is kept for the next request.
- enable=0:
  - state forced to S_FETCH_I, buf_valid <= 0, no fifo_rd.
  - sample_stb gives a zero sample and iq_stb, with no underrun pulse and no count.
  - A byte already read in S_CAP_I/S_CAP_Q is discarded. The host must refill whole pairs after re-enable.
- count_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values: state S_FETCH_I, buf_valid 0, buf_i/buf_q 0, iq_i 0, iq_q 0, iq_stb 0, underrun 0, underrun_count 0, fifo_rd 0.
- FIFO read latency is 1: data requested by fifo_rd in cycle N is captured in cycle N+1.
- Request to output: sample_stb in cycle N gives updated iq_i/iq_q and iq_stb/underrun visible after edge N+1.
- Refill after consumption at stb cycle N, with the FIFO non-empty:
  - S_FETCH_I at N+1, S_CAP_I at N+2, S_FETCH_Q at N+3, S_CAP_Q at N+4.
  - buf_valid=1 from N+5.
  - Minimum sample_stb spacing without underrun is 5 cycles.
- From reset/enable with ≥2 bytes available, buf_valid=1 on the 5th cycle.
- iq_stb, underrun and fifo_rd are single-cycle pulses.
- iq_i/iq_q hold their value between strobes.

## Test plan
- Fill FIFO with 0x11,0x22,0x33,0x44; enable; sample_stb every 8 cycles:
  - outputs (0x11,0x22) then (0x33,0x44), then (0,0) with underrun=1 and count=1.
  - exactly 4 fifo_rd pulses.
- sample_stb 2 cycles after enable with FIFO holding 0x7F,0x80:
  - underrun, zero sample, count=1.
  - next stb gives (0x7F,0x80).
- FIFO holds only 0x05: state parks in S_FETCH_Q, no further fifo_rd. Push 0x06: the next stb gives (0x05,0x06).
- Force underrun_count to 16'hFFFE, issue 3 underruns: count=FFFF and stays. Assert count_clr with a simultaneous underrun: count=0.
- Drop enable in S_CAP_I:
  - buf_valid=0, no rd while low, stb gives zeros and count unchanged.
  - re-enable resumes at S_FETCH_I.
- Assert rst asynchronously mid-fetch: all outputs are at their reset values immediately, and there is no fifo_rd until rst is released.
